imem_port: RTL and testbench

- Instruction-memory port controller between the fetch stage and the instruction bus/SRAM.
- Accepts the fetch stage's level-held read request (PC) and runs a valid/ready request plus response handshake on the memory side.
- Returns one single-cycle instruction response, with fault reporting for misaligned, out-of-range and timed-out accesses.
- Optionally short-circuits repeated fetches of the same word through a one-entry word buffer.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_word_buf.sv | 51 +++++
 rtl/imem_port.sv | 176 +++++++++++++++++
 tb/tb_imem_port.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory port controller.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  // Late responses still owed by the bus for requests that already timed out.
  localparam int unsigned     ORPHAN_W   = 2;
  localparam logic [ORPHAN_W-1:0] ORPHAN_MAX = '1;

endpackage

// File: rtl/imem_word_buf.sv
// One-entry instruction word buffer: remembers the last word fetched from the bus so an
// immediate re-fetch of the same index can be answered without a bus transaction.
module imem_word_buf #(
  parameter int unsigned IdxW = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inv_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [31:0]     wr_data_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            hit_o,
  output logic [31:0]     hit_data_o
);

  logic            valid_q, valid_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     data_q, data_d;

  // Invalidation wins over a same-cycle fill.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (inv_i) begin
      valid_d = 1'b0;
    end else if (wr_en_i) begin
      valid_d = 1'b1;
      idx_d   = wr_idx_i;
      data_d  = wr_data_i;
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign hit_o      = valid_q && (idx_q == rd_idx_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/imem_port.sv
// Instruction-memory port controller: turns a level-held fetch request into one bus
// transaction and a single-cycle response, reporting misaligned, out-of-range and
// timed-out accesses. Build option IMEM_WORD_BUF_EN adds a one-entry word buffer that
// answers a repeated fetch of the same word without touching the bus; fence_i clears it.
module imem_port
  import imem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned TIMEOUT   = 255,
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1,
  localparam int unsigned CW = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_read_req_valid,
  input  logic [31:0]   instr_read_req_addr,
  output logic          instr_read_res_valid,
  output logic [31:0]   instr_read_res_data,
  output logic          instr_read_res_fault,
  output logic [1:0]    instr_fault_cause,
  input  logic          fence_i,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_res_valid,
  input  logic [31:0]   mem_res_data
);

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          cause_q, cause_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ORPHAN_W-1:0] orphan_q, orphan_d;

  logic                orphan_inc, orphan_dec;
  logic                buf_wr, fault_evt;
  logic                buf_hit;
  logic [31:0]         buf_data;

  // Address decode on the live request; MEM_BASE is assumed word aligned.
  logic [29:0]   word_off;
  logic          aligned, in_range;
  logic [AW-1:0] req_idx;

  assign word_off = instr_read_req_addr[31:2] - MEM_BASE[31:2];
  assign aligned  = (instr_read_req_addr[1:0] == 2'b00);
  assign in_range = (instr_read_req_addr[31:2] >= MEM_BASE[31:2]) &&
                    ({2'b00, word_off} < 32'(MEM_WORDS));
  assign req_idx  = word_off[AW-1:0];

`ifdef IMEM_WORD_BUF_EN
  imem_word_buf #(
    .IdxW (AW)
  ) u_word_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .inv_i      (fence_i | fault_evt),
    .wr_en_i    (buf_wr),
    .wr_idx_i   (idx_q),
    .wr_data_i  (mem_res_data),
    .rd_idx_i   (req_idx),
    .hit_o      (buf_hit),
    .hit_data_o (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
  logic unused_buf;
  assign unused_buf = buf_wr ^ fault_evt;
`endif

  // Next-state and datapath for the fetch FSM plus the orphan-response tracker.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    orphan_d   = orphan_q;
    orphan_inc = 1'b0;
    buf_wr     = 1'b0;
    fault_evt  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (instr_read_req_valid) begin
          if (!aligned) begin
            cause_d   = FAULT_MISALIGN;
            data_d    = '0;
            fault_evt = 1'b1;
            state_d   = StResp;
          end else if (!in_range) begin
            cause_d   = FAULT_RANGE;
            data_d    = '0;
            fault_evt = 1'b1;
            state_d   = StResp;
          end else if (buf_hit && !fence_i) begin
            // A same-cycle fence must not be answered from the stale entry.
            idx_d   = req_idx;
            cause_d = FAULT_NONE;
            data_d  = buf_data;
            state_d = StResp;
          end else begin
            idx_d   = req_idx;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_res_valid && (orphan_q == '0)) begin
          cause_d = FAULT_NONE;
          data_d  = mem_res_data;
          buf_wr  = 1'b1;
          state_d = StResp;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // TIMEOUT wait cycles have elapsed with no usable response.
          cause_d    = FAULT_TIMEOUT;
          data_d     = '0;
          fault_evt  = 1'b1;
          orphan_inc = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Any bus response while orphans are owed belongs to an abandoned request.
    orphan_dec = mem_res_valid && (orphan_q != '0);
    if (orphan_inc && !orphan_dec) begin
      orphan_d = (orphan_q == ORPHAN_MAX) ? orphan_q : orphan_q + ORPHAN_W'(1);
    end else if (orphan_dec && !orphan_inc) begin
      orphan_d = orphan_q - ORPHAN_W'(1);
    end
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      data_q   <= '0;
      cause_q  <= FAULT_NONE;
      cnt_q    <= '0;
      orphan_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end

  assign instr_read_res_valid = (state_q == StResp);
  assign instr_read_res_data  = instr_read_res_valid ? data_q : '0;
  assign instr_read_res_fault = instr_read_res_valid && (cause_q != FAULT_NONE);
  assign instr_fault_cause    = instr_read_res_valid ? cause_q : FAULT_NONE;
  assign mem_req_valid        = (state_q == StReq);
  assign mem_req_addr         = idx_q;

endmodule

// File: tb/tb_imem_port.sv
// Scoreboard bench for imem_port: a fetch driver predicts each response from the address
// map, the bus schedule it plays and a count of stale responses the bus still owes; a
// monitor pops and compares whenever the port presents a response.
module tb_imem_port;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WORDS = 4096;
  localparam int unsigned TOUT  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_fault;
  logic [1:0]  res_cause;
  logic        fence;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [11:0] mem_req_addr;
  logic        mem_res_valid;
  logic [31:0] mem_res_data;

  always #5 clk = ~clk;

  imem_port #(
    .MEM_BASE  (BASE),
    .MEM_WORDS (WORDS),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .instr_read_req_valid (req_valid),
    .instr_read_req_addr  (req_addr),
    .instr_read_res_valid (res_valid),
    .instr_read_res_data  (res_data),
    .instr_read_res_fault (res_fault),
    .instr_fault_cause    (res_cause),
    .fence_i              (fence),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_res_valid        (mem_res_valid),
    .mem_res_data         (mem_res_data)
  );

  typedef struct packed {
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  bit          bus_exp = 1'b0;
  logic [11:0] exp_idx = '0;

  // Reference model state: stale responses owed, and the remembered word.
  int          orph = 0;
  bit          bv = 1'b0;
  logic [31:0] bidx = '0;
  logic [31:0] bdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: response scoreboard and bus-request legality.
  always @(negedge clk) begin
    if (res_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_resp: res_valid with nothing expected (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (res_fault !== mon_e.fault || res_cause !== mon_e.cause ||
            res_data !== mon_e.data || 32'(cyc) != mon_e.cyc) begin
          n_bad++;
          $display("FAIL resp: actual fault=%0b cause=%b data=%h cycle=%0d required fault=%0b cause=%b data=%h cycle=%0d",
                   res_fault, res_cause, res_data, cyc, mon_e.fault, mon_e.cause, mon_e.data,
                   mon_e.cyc);
        end
      end
    end
    if (mem_req_valid) begin
      n_cmp++;
      if (!bus_exp || mem_req_addr !== exp_idx) begin
        n_bad++;
        $display("FAIL mem_req: actual valid=1 idx=%h required bus_expected=%0b idx=%h (cycle %0d)",
                 mem_req_addr, bus_exp, exp_idx, cyc);
      end
      if (mem_req_ready) hs_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_map(input logic [31:0] a);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * longint'(WORDS));
  endfunction

  // One fetch: predict the response, push it, then play the fetch and bus sides.
  // soff_in = 0 picks a random first-response offset that still beats the timeout.
  task automatic fetch(input logic [31:0] addr, input int rdly, input bit silent,
                       input int soff_in, input int hold, input bit fix_data,
                       input logic [31:0] fdata);
    int          c, h, soff, nj, hs0;
    logic [31:0] widx, rdata;
    exp_t        e;
    bit          on_bus;
    c      = cyc;
    hs0    = hs_cnt;
    on_bus = 1'b0;
    h      = 0;
    nj     = 0;
    soff   = 1;
    widx   = (addr - BASE) >> 2;
    rdata  = fix_data ? fdata : $urandom;
    if (addr % 4 != 0) begin
      e  = '{1'b1, 2'b01, 32'h0, 32'(c + 1)};
      bv = 1'b0;
    end else if (!in_map(addr)) begin
      e  = '{1'b1, 2'b10, 32'h0, 32'(c + 1)};
      bv = 1'b0;
`ifdef IMEM_WORD_BUF_EN
    end else if (bv && bidx == widx) begin
      e = '{1'b0, 2'b00, bdata, 32'(c + 1)};
`endif
    end else begin
      on_bus = 1'b1;
      h      = c + 1 + rdly;
      nj     = orph;
      soff   = (soff_in > 0) ? soff_in : int'($urandom_range(1, TOUT - nj));
      if (silent) begin
        e    = '{1'b1, 2'b11, 32'h0, 32'(h + TOUT + 1)};
        bv   = 1'b0;
        orph = (orph < 3) ? orph + 1 : 3;
      end else begin
        e     = '{1'b0, 2'b00, rdata, 32'(h + soff + nj + 1)};
        bv    = 1'b1;
        bidx  = widx;
        bdata = rdata;
        orph  = 0;
      end
    end
    sb_q.push_back(e);
    bus_exp   = on_bus;
    exp_idx   = widx[11:0];
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    if (hold < 2) req_valid = 1'b0;
    req_addr = $urandom;
    if (!on_bus) begin
      step();
      req_valid = 1'b0;
    end else begin
      for (int i = 0; i < rdly; i++) begin
        step();
        req_valid = 1'b0;
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      req_valid     = 1'b0;
      bus_exp       = 1'b0;
      if (silent) begin
        repeat (TOUT) step();
      end else begin
        for (int k = 1; k <= soff + nj; k++) begin
          mem_res_valid = (k >= soff);
          mem_res_data  = (k == soff + nj) ? rdata : $urandom;
          step();
        end
        mem_res_valid = 1'b0;
        mem_res_data  = '0;
      end
      step();
    end
    check("bus_requests", 32'(hs_cnt - hs0), 32'(on_bus));
  endtask

  task automatic idle_junk();
    if (orph > 0) begin
      mem_res_valid = 1'b1;
      mem_res_data  = $urandom;
      step();
      mem_res_valid = 1'b0;
      orph--;
    end
  endtask

  task automatic pulse_fence();
    fence = 1'b1;
    step();
    fence = 1'b0;
`ifdef IMEM_WORD_BUF_EN
    bv = 1'b0;
`endif
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0000_0040;
          1:       a = 32'h0000_0044;
          2:       a = 32'h0000_0000;
          default: a = 32'h0000_3FFC;
        endcase
      end
      3, 4, 5: a = 32'($urandom_range(0, WORDS - 1)) * 4;
      6:       a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
      7:       a = 32'h0000_4000 + 4 * 32'($urandom_range(0, 1000));
      8:       a = $urandom & 32'hFFFF_FFFC;
      default: a = $urandom_range(0, 1) ? 32'h0000_4000 : 32'hFFFF_FFFC;
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    fence         = 1'b0;
    mem_req_ready = 1'b0;
    mem_res_valid = 1'b0;
    mem_res_data  = '0;
    repeat (2) step();
    check("reset_res_valid", 32'(res_valid), 32'h0);
    check("reset_res_data", res_data, 32'h0);
    check("reset_res_fault", 32'(res_fault), 32'h0);
    check("reset_fault_cause", 32'(res_cause), 32'h0);
    check("reset_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check("reset_mem_req_addr", 32'(mem_req_addr), 32'h0);
    rst = 1'b0;
    step();

    // Zero-wait fetch, misaligned, out-of-range boundary.
    fetch(32'h0000_0010, 0, 1'b0, 1, 1, 1'b1, 32'h0000_0013);
    fetch(32'h0000_0006, 0, 1'b0, 0, 1, 1'b0, 32'h0);
    fetch(32'h0000_4000, 0, 1'b0, 0, 2, 1'b0, 32'h0);

    // Timeout leaves one stale response owed; the next fetch must skip it.
    fetch(32'h0000_0020, 0, 1'b1, 0, 1, 1'b0, 32'h0);
    fetch(32'h0000_0024, 0, 1'b0, 1, 1, 1'b1, 32'hB0B0_B0B0);

    // Repeated word, then fence, then the same word again.
    fetch(32'h0000_0040, 1, 1'b0, 0, 1, 1'b0, 32'h0);
    fetch(32'h0000_0040, 0, 1'b0, 0, 2, 1'b0, 32'h0);
    pulse_fence();
    fetch(32'h0000_0040, 0, 1'b0, 0, 1, 1'b0, 32'h0);

    // Back-pressure, then reset in the third stalled cycle.
    bus_exp   = 1'b1;
    exp_idx   = 12'h040;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    check("bp_hold_1", 32'(mem_req_valid), 32'h1);
    step();
    check("bp_hold_2", 32'(mem_req_valid), 32'h1);
    step();
    check("bp_hold_3", 32'(mem_req_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_async_mem_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_async_res_valid", 32'(res_valid), 32'h0);
    step();
    step();
    rst     = 1'b0;
    bus_exp = 1'b0;
    orph    = 0;
    bv      = 1'b0;
    mem_req_ready = 1'b1;
    repeat (5) step();
    mem_req_ready = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    idle_junk();
        2:       pulse_fence();
        3:       step();
        default: ;
      endcase
      fetch(rand_addr(), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 0,
            int'($urandom_range(1, 2)), 1'b0, 32'h0);
    end

    repeat (3) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
